// File: rtl/hyper_evt_pkg.sv
// Shared types and helpers for the uDMA HyperBus end-of-transfer tracker.
package hyper_evt_pkg;

    typedef enum logic {
        HYPER_DIR_WRITE = 1'b0,
        HYPER_DIR_READ  = 1'b1
    } hyper_dir_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned pend_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hyper_dir_fifo.sv
// Ordered queue of direction tags with two prioritized push ports and one pop port.
// A pop in the same cycle frees its slot for either push.
module hyper_dir_fifo
    import hyper_evt_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = pend_w(DEPTH),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr0_i,
    input  hyper_dir_e    wr0_tag_i,
    input  logic          wr1_i,
    input  hyper_dir_e    wr1_tag_i,
    input  logic          rd_i,
    output hyper_dir_e    head_tag_o,
    output logic          pop_o,
    output logic          orphan_o,
    output logic          ovf_o,
    output logic [PW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    hyper_dir_e    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic [PW-1:0] free_slots;
    logic          pop, acc0, acc1;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        pop        = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        free_slots = '0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;

        // Pop is decided on pre-edge occupancy, so an eot on an empty queue is an orphan.
        pop        = rd_i && (count_q != '0);
        free_slots = DEPTH_C - count_q + PW'(pop);
        acc0       = wr0_i && (free_slots != '0);
        acc1       = wr1_i && (free_slots > PW'(acc0));

        wptr_d  = wptr_q + AW'(acc0) + AW'(acc1);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + PW'(acc0) + PW'(acc1) - PW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: tag storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (acc0) mem_q[wptr_q] <= wr0_tag_i;
            if (acc1) mem_q[wptr_q + AW'(acc0)] <= wr1_tag_i;
        end
    end

    assign head_tag_o = mem_q[rptr_q];
    assign pop_o      = pop;
    assign orphan_o   = rd_i && (count_q == '0);
    assign ovf_o      = (wr0_i && !acc0) || (wr1_i && !acc1);
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/udma_hyper_evt_tracker.sv
// Classifies HyperBus end-of-transfer pulses as read or write completions using
// the order of RX/TX end events; provides done pulses, saturating counters and sticky errors.
module udma_hyper_evt_tracker
    import hyper_evt_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned PW    = pend_w(DEPTH)
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             rx_evt_i,
    input  logic             tx_evt_i,
    input  logic             eot_i,
    input  logic             cnt_clr_i,
    input  logic             err_clr_i,
    output logic             read_done_o,
    output logic             write_done_o,
    output logic [PW-1:0]    pending_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic             err_ovf_o,
    output logic             err_orphan_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hyper_dir_e       head_tag;
    logic             pop, orphan, ovf;
    logic             read_done_q, read_done_d;
    logic             write_done_q, write_done_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_orphan_q, err_orphan_d;

    hyper_dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (sys_clk_i),
        .rst_i      (rst_i),
        .wr0_i      (rx_evt_i),
        .wr0_tag_i  (HYPER_DIR_READ),
        .wr1_i      (tx_evt_i),
        .wr1_tag_i  (HYPER_DIR_WRITE),
        .rd_i       (eot_i),
        .head_tag_o (head_tag),
        .pop_o      (pop),
        .orphan_o   (orphan),
        .ovf_o      (ovf),
        .count_o    (pending_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    always_comb begin
        read_done_d  = pop && (head_tag == HYPER_DIR_READ);
        write_done_d = pop && (head_tag == HYPER_DIR_WRITE);

        // Clear beats a same-cycle increment; counters stick at all-ones.
        rd_cnt_d = rd_cnt_q;
        if (cnt_clr_i)                              rd_cnt_d = '0;
        else if (read_done_d && rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;

        wr_cnt_d = wr_cnt_q;
        if (cnt_clr_i)                               wr_cnt_d = '0;
        else if (write_done_d && wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;

        // A new error beats a same-cycle clear.
        err_ovf_d    = ovf    || (err_ovf_q    && !err_clr_i);
        err_orphan_d = orphan || (err_orphan_q && !err_clr_i);
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            err_ovf_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            err_ovf_q    <= err_ovf_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign read_done_o  = read_done_q;
    assign write_done_o = write_done_q;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign err_ovf_o    = err_ovf_q;
    assign err_orphan_o = err_orphan_q;

endmodule

// File: tb/tb_udma_hyper_evt_tracker.sv
// Directed plus random stimulus for udma_hyper_evt_tracker, compared each cycle
// against a queue-based reference model of the tag ordering rules.
module tb_udma_hyper_evt_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             sys_clk_i = 1'b0;
    logic             rst_i, rx_evt_i, tx_evt_i, eot_i, cnt_clr_i, err_clr_i;
    logic             read_done_o, write_done_o, full_o, empty_o;
    logic [PW-1:0]    pending_o;
    logic [CNT_W-1:0] rd_cnt_o, wr_cnt_o;
    logic             err_ovf_o, err_orphan_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: 1 = read tag, 0 = write tag, head at index 0.
    bit q[$];
    int m_rd, m_wr;
    bit m_ovf, m_orph, m_rdd, m_wrd;

    udma_hyper_evt_tracker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk_i    (sys_clk_i),
        .rst_i        (rst_i),
        .rx_evt_i     (rx_evt_i),
        .tx_evt_i     (tx_evt_i),
        .eot_i        (eot_i),
        .cnt_clr_i    (cnt_clr_i),
        .err_clr_i    (err_clr_i),
        .read_done_o  (read_done_o),
        .write_done_o (write_done_o),
        .pending_o    (pending_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .rd_cnt_o     (rd_cnt_o),
        .wr_cnt_o     (wr_cnt_o),
        .err_ovf_o    (err_ovf_o),
        .err_orphan_o (err_orphan_o)
    );

    initial forever #5 sys_clk_i = ~sys_clk_i;

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_edge(input bit rst, rx, tx, eot, cc, ec);
        int  free;
        bit  pop, orph, ovf, rdd, wrd;
        if (rst) begin
            q.delete();
            m_rd = 0; m_wr = 0;
            m_ovf = 0; m_orph = 0; m_rdd = 0; m_wrd = 0;
            return;
        end
        pop  = eot && (q.size() > 0);
        orph = eot && (q.size() == 0);
        rdd  = 0;
        wrd  = 0;
        if (pop) begin
            if (q.pop_front()) rdd = 1;
            else               wrd = 1;
        end
        free = DEPTH - q.size();
        ovf  = 0;
        if (rx) begin
            if (free > 0) begin q.push_back(1'b1); free--; end
            else ovf = 1;
        end
        if (tx) begin
            if (free > 0) begin q.push_back(1'b0); free--; end
            else ovf = 1;
        end
        if (cc) begin
            m_rd = 0; m_wr = 0;
        end else begin
            if (rdd && m_rd < CMAX) m_rd++;
            if (wrd && m_wr < CMAX) m_wr++;
        end
        m_ovf  = ovf  | (m_ovf  & ~ec);
        m_orph = orph | (m_orph & ~ec);
        m_rdd  = rdd;
        m_wrd  = wrd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":read_done"},  int'(read_done_o),  int'(m_rdd));
        chk({tag, ":write_done"}, int'(write_done_o), int'(m_wrd));
        chk({tag, ":pending"},    int'(pending_o),    q.size());
        chk({tag, ":full"},       int'(full_o),       int'(q.size() == DEPTH));
        chk({tag, ":empty"},      int'(empty_o),      int'(q.size() == 0));
        chk({tag, ":rd_cnt"},     int'(rd_cnt_o),     m_rd);
        chk({tag, ":wr_cnt"},     int'(wr_cnt_o),     m_wr);
        chk({tag, ":err_ovf"},    int'(err_ovf_o),    int'(m_ovf));
        chk({tag, ":err_orphan"}, int'(err_orphan_o), int'(m_orph));
    endtask

    // Apply one cycle of inputs, advance the model on the same edge, then check.
    task automatic step(input string tag, input bit rst, rx, tx, eot, cc, ec);
        rst_i     = rst;
        rx_evt_i  = rx;
        tx_evt_i  = tx;
        eot_i     = eot;
        cnt_clr_i = cc;
        err_clr_i = ec;
        @(posedge sys_clk_i);
        model_edge(rst, rx, tx, eot, cc, ec);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_i = 1'b1; rx_evt_i = 1'b0; tx_evt_i = 1'b0;
        eot_i = 1'b0; cnt_clr_i = 1'b0; err_clr_i = 1'b0;
        m_rd = 0; m_wr = 0; m_ovf = 0; m_orph = 0; m_rdd = 0; m_wrd = 0;

        // Reset state
        step("rst", 1, 0, 0, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0, 0);
        chk("rst_empty_const", int'(empty_o), 1);

        // Single read, 1-cycle done latency
        step("rd1_push", 0, 1, 0, 0, 0, 0);
        repeat (3) step("rd1_idle", 0, 0, 0, 0, 0, 0);
        step("rd1_eot", 0, 0, 0, 1, 0, 0);
        chk("rd1_done_const", int'(read_done_o), 1);
        chk("rd1_cnt_const", int'(rd_cnt_o), 1);
        step("rd1_after", 0, 0, 0, 0, 0, 0);

        // Same-cycle rx/tx: read ordered first
        step("rxtx_push", 0, 1, 1, 0, 0, 0);
        chk("rxtx_pend2", int'(pending_o), 2);
        step("rxtx_eot1", 0, 0, 0, 1, 0, 0);
        chk("rxtx_rd_first", int'(read_done_o), 1);
        step("rxtx_eot2", 0, 0, 0, 1, 0, 0);
        chk("rxtx_wr_second", int'(write_done_o), 1);
        step("rxtx_idle", 0, 0, 0, 0, 0, 0);

        // Fill, overflow, and push-with-pop at full
        repeat (4) step("fill", 0, 0, 1, 0, 0, 0);
        chk("fill_full", int'(full_o), 1);
        step("ovf", 0, 0, 1, 0, 0, 0);
        chk("ovf_flag", int'(err_ovf_o), 1);
        step("ovf_clr", 0, 0, 0, 0, 0, 1);
        step("full_push_pop", 0, 0, 1, 1, 0, 0);
        chk("full_push_pop_noerr", int'(err_ovf_o), 0);
        chk("full_push_pop_pend", int'(pending_o), 4);
        step("both_at_full", 0, 1, 1, 1, 0, 0);
        repeat (5) step("drain", 0, 0, 0, 1, 0, 0);

        // Orphan eot and clear priority
        step("orphan", 0, 0, 0, 1, 0, 0);
        chk("orphan_flag", int'(err_orphan_o), 1);
        step("err_clr", 0, 0, 0, 0, 0, 1);
        step("orphan2", 0, 0, 0, 1, 0, 0);
        step("clr_vs_set", 0, 0, 0, 1, 0, 1);
        chk("clr_vs_set_const", int'(err_orphan_o), 1);
        step("push_orphan", 0, 1, 0, 1, 0, 1);
        step("pop_it", 0, 0, 0, 1, 0, 0);

        // Saturating read counter and clear-wins
        for (int i = 0; i < 17; i++) begin
            step("sat_push", 0, 1, 0, 0, 0, 0);
            step("sat_pop", 0, 0, 0, 1, 0, 0);
        end
        chk("sat_const", int'(rd_cnt_o), CMAX);
        step("clr_push", 0, 1, 0, 0, 0, 0);
        step("clr_pop", 0, 0, 0, 1, 1, 0);
        chk("clr_pop_const", int'(rd_cnt_o), 0);

        // Reset mid-operation discards the pop
        repeat (3) step("pre_rst", 0, 1, 0, 0, 0, 0);
        step("rst_mid", 1, 0, 0, 1, 0, 0);
        chk("rst_mid_nodone", int'(read_done_o), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(99) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(1) == 0),
                 ($urandom_range(29) == 0),
                 ($urandom_range(9) == 0));
        end

        step("final", 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
